piece_collision_checker: RTL
============================

// Module: piece_collision_checker
// PURPOSE
//  Sequential collision checker for a whole tetromino against board RAM. Given NCELLS cell coords,
//  scans each cell, reads its board RAM colour, flags a hit on a nonzero colour or an out-of-bounds
//  coord, and reports a verdict with a start/done handshake. Sits between the piece-movement FSM
//  and the board RAM read port. Board W/H, coord widths and RAM read latency are parametrised.
// PARAMETERS
//  BOARD_W   10  board width in cells
//  BOARD_H   24  board height in cells
//  NCELLS    4   cells per piece
//  X_W       5   X coord width
//  Y_W       6   Y coord width
//  ADDR_W    8   RAM address width; must be >= clog2(BOARD_W*BOARD_H)
//  COLOUR_W  6   RAM data (colour) width; 0 = empty cell
//  RAM_LAT   1   RAM read latency in cycles (>=1)
// PORTS
//  clk        in   1               system clock, rising edge
//  reset      in   1               async, active-high reset
//  start      in   1               request a check; sampled only when busy=0
//  cells_x    in   NCELLS*X_W      packed X coords; cell i = [i*X_W +: X_W]
//  cells_y    in   NCELLS*Y_W      packed Y coords; cell i = [i*Y_W +: Y_W]
//  ram_Q      in   COLOUR_W        board RAM read data
//  ram_addr   out  ADDR_W          board RAM read address
//  ram_req    out  1               high while busy; top level muxes RAM address/holds wren low
//  busy       out  1               scan in progress
//  done       out  1               one-cycle pulse: verdict valid
//  collision  out  1               verdict; held until next accepted start
//  hit_index  out  clog2(NCELLS)   lowest-numbered colliding cell; 0 if none
// BEHAVIOUR
//  - Reset (async): state IDLE; ram_addr, ram_req, busy, done, collision, hit_index all 0.
//  - States: IDLE -> ADDR -> WAIT (RAM_LAT-1 cycles, skipped if RAM_LAT=1) -> SAMPLE -> ADDR (next
//    cell) or DONE -> IDLE. DONE lasts exactly one cycle (done=1).
//  - IDLE: start=1 latches cells_x/cells_y, clears collision/hit_index, sets busy/ram_req, goes to ADDR.
//  - Cell i period = RAM_LAT+1 cycles. With start sampled at edge ending cycle 0, cell i address
//    driven in cycle 1+i*(RAM_LAT+1); ram_Q sampled RAM_LAT cycles later.
//  - ram_addr = Y*BOARD_W + X computed at ADDR_W bits (no truncation for in-bounds coords); held for
//    the whole cell period; 0 in IDLE/DONE and for out-of-bounds cells.
//  - Cell hits if X>=BOARD_W or Y>=BOARD_H (ram_Q ignored) or |ram_Q. Out-of-bounds cells still
//    consume a full period (fixed timing).
//  - First hit sets collision=1 and hit_index=i; later hits do not change hit_index.
//  - done cycle (full scan) = NCELLS*(RAM_LAT+1)+1 after start; defaults -> cycle 9. busy=0 in DONE.
//  - start while busy or in DONE ignored. Coord inputs may change after start (latched copy used).
//  - Reset mid-scan: immediate IDLE, all outputs 0, no done pulse.
// CONFIGURATION
//  PIECE_COLLISION_EARLY_EXIT_EN defined: after SAMPLE of first hit go straight to DONE; cell i hit ->
//   done in cycle (i+1)*(RAM_LAT+1)+1. Not defined: always scan all NCELLS cells; done timing fixed.
//  Verdict (collision, hit_index) identical in both builds.
// TESTING
//  1 Empty RAM, cells (3,0)(4,0)(5,0)(4,1) -> ram_addr 3,4,5,14 each 2 cycles; done cycle 9; collision=0.
//  2 RAM[14]=6'h2A, same piece -> collision=1, hit_index=3; done cycle 9.
//  3 Empty RAM, cell2=(4,24), cell1=(10,3) -> collision=1, hit_index=1; cell1/2 ram_addr=0.
//  4 EARLY_EXIT_EN, RAM[3]!=0, piece of test 1 -> done cycle 3, collision=1, hit_index=0, ram_req
//    falls after cycle 2; without macro done still cycle 9.
//  5 start re-pulsed in cycles 2-8 -> ignored, single done; reset at cycle 4 -> outputs 0, no done,
//    next start behaves as fresh scan.
//  6 RAM_LAT=2, RAM_LAT=3 model, test 2 stimulus -> done at cycle 13 / 17, ram_addr held 3 / 4 cycles.

Source files
------------

// File: rtl/piece_collision_checker.sv
// Sequential tetromino collision checker: scans NCELLS cells against board RAM, start/done handshake.
// Optional build macro PIECE_COLLISION_EARLY_EXIT_EN stops the scan at the first colliding cell.
module piece_collision_checker #(
    parameter int unsigned BOARD_W  = 10,
    parameter int unsigned BOARD_H  = 24,
    parameter int unsigned NCELLS   = 4,
    parameter int unsigned X_W      = 5,
    parameter int unsigned Y_W      = 6,
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned COLOUR_W = 6,
    parameter int unsigned RAM_LAT  = 1,
    localparam int unsigned IDX_W   = (NCELLS > 1) ? $clog2(NCELLS) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [NCELLS*X_W-1:0]    cells_x,
    input  logic [NCELLS*Y_W-1:0]    cells_y,
    input  logic [COLOUR_W-1:0]      ram_Q,
    output logic [ADDR_W-1:0]        ram_addr,
    output logic                     ram_req,
    output logic                     busy,
    output logic                     done,
    output logic                     collision,
    output logic [IDX_W-1:0]         hit_index
);

    localparam int unsigned CNT_W = (RAM_LAT > 2) ? $clog2(RAM_LAT - 1) : 1;

    typedef enum logic [2:0] {StIdle, StAddr, StWait, StSample, StDone} state_e;

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]        wcnt_q, wcnt_d;
    logic [NCELLS*X_W-1:0]   cx_q, cx_d;
    logic [NCELLS*Y_W-1:0]   cy_q, cy_d;
    logic                    coll_q, coll_d;
    logic [IDX_W-1:0]        hidx_q, hidx_d;

    logic [X_W-1:0]          cur_x;
    logic [Y_W-1:0]          cur_y;
    logic [ADDR_W-1:0]       cell_addr;
    logic                    oob;
    logic                    cell_hit;
    logic                    in_scan;
    logic                    last_cell;
    logic                    exit_scan;

    assign cur_x     = cx_q[int'(idx_q)*X_W +: X_W];
    assign cur_y     = cy_q[int'(idx_q)*Y_W +: Y_W];
    assign oob       = (32'(cur_x) >= BOARD_W) || (32'(cur_y) >= BOARD_H);
    assign cell_addr = ADDR_W'(cur_y) * ADDR_W'(BOARD_W) + ADDR_W'(cur_x);
    // Out-of-bounds cells collide regardless of whatever the RAM returns for address 0.
    assign cell_hit  = oob || (|ram_Q);
    assign in_scan   = state_q inside {StAddr, StWait, StSample};
    assign last_cell = (idx_q == IDX_W'(NCELLS - 1));

    assign ram_addr  = (in_scan && !oob) ? cell_addr : '0;
    assign ram_req   = in_scan;
    assign busy      = in_scan;
    assign done      = (state_q == StDone);
    assign collision = coll_q;
    assign hit_index = hidx_q;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        wcnt_d    = wcnt_q;
        cx_d      = cx_q;
        cy_d      = cy_q;
        coll_d    = coll_q;
        hidx_d    = hidx_q;
`ifdef PIECE_COLLISION_EARLY_EXIT_EN
        exit_scan = last_cell || cell_hit;
`else
        exit_scan = last_cell;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    cx_d    = cells_x;
                    cy_d    = cells_y;
                    coll_d  = 1'b0;
                    hidx_d  = '0;
                    idx_d   = '0;
                    state_d = StAddr;
                end
            end
            StAddr: begin
                wcnt_d  = '0;
                state_d = (RAM_LAT > 1) ? StWait : StSample;
            end
            StWait: begin
                if (wcnt_q == CNT_W'(RAM_LAT - 2)) begin
                    state_d = StSample;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            StSample: begin
                if (cell_hit && !coll_q) begin
                    coll_d = 1'b1;
                    hidx_d = idx_q;
                end
                if (exit_scan) begin
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = StAddr;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            idx_q   <= '0;
            wcnt_q  <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            coll_q  <= 1'b0;
            hidx_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wcnt_q  <= wcnt_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            coll_q  <= coll_d;
            hidx_q  <= hidx_d;
        end
    end

endmodule
